// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// One quotient bit per cycle; the sign fix is applied as the last step retires.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIVZ = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_quo_r;
    logic             neg_rem_r;

    logic             accept_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    // Two's-complement negation; 0x80..0 maps onto itself, which the
    // unsigned core then treats as 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand conditioning and one restoring step of the datapath.
    always_comb begin
        accept_s = start_i & ~cancel_i;
        a_neg_s  = signed_i & dividend_i[WIDTH-1];
        b_neg_s  = signed_i & divisor_i[WIDTH-1];
        if (a_neg_s) begin
            a_abs_s = neg2(dividend_i);
        end else begin
            a_abs_s = dividend_i;
        end
        if (b_neg_s) begin
            b_abs_s = neg2(divisor_i);
        end else begin
            b_abs_s = divisor_i;
        end
        // Partial remainder stays below the divisor, so WIDTH+1 bits
        // hold both the shifted value and the signed trial difference.
        shift_s = {rem_r, quo_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, dvs_r};
        if (trial_s[WIDTH]) begin
            rem_step_s = shift_s[WIDTH-1:0];
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
        end
        quo_step_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
        if (neg_quo_r) begin
            quo_fix_s = neg2(quo_step_s);
        end else begin
            quo_fix_s = quo_step_s;
        end
        if (neg_rem_r) begin
            rem_fix_s = neg2(rem_step_s);
        end else begin
            rem_fix_s = rem_step_s;
        end
    end

    // Next-state logic; cancel wins over every transition.
    always_comb begin
        state_next_s = state_r;
        if (cancel_i) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == ZERO_W) begin
                            state_next_s = DIVZ;
                        end else begin
                            state_next_s = BUSY;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DIVZ: state_next_s = DONE;
                BUSY: begin
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
                end
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= ZERO_W;
            quo_r       <= ZERO_W;
            dvs_r       <= ZERO_W;
            neg_quo_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            div_zero_o  <= 1'b0;
            quotient_o  <= ZERO_W;
            remainder_o <= ZERO_W;
        end else begin
            state_r <= state_next_s;
            busy_o  <= (state_next_s != IDLE);
            ready_o <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rem_r      <= ZERO_W;
                        quo_r      <= a_abs_s;
                        dvs_r      <= b_abs_s;
                        neg_quo_r  <= a_neg_s ^ b_neg_s;
                        neg_rem_r  <= a_neg_s;
                        cnt_r      <= {CW{1'b0}};
                        div_zero_o <= 1'b0;
                    end
                end
                DIVZ: begin
                    if (!cancel_i) begin
                        quotient_o  <= ZERO_W;
                        remainder_o <= ZERO_W;
                        div_zero_o  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!cancel_i) begin
                        rem_r <= rem_step_s;
                        quo_r <= quo_step_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            quotient_o  <= quo_fix_s;
                            remainder_o <= rem_fix_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// checked against an arithmetic reference built on 64-bit integer division.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        cancel_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        ready_o;
    logic        div_zero_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_q = 32'd0;
    logic [31:0] prev_r = 32'd0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .cancel_i   (cancel_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .div_zero_o (div_zero_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on 64-bit integers, so -2^31 / -1 = 2^31.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, ql, rl;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; dz = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
            ql = sa / sb;
            rl = sa % sb;
            q = ql[31:0]; r = rl[31:0]; dz = 1'b0;
        end
    endfunction

    // One operation from an idle negedge. abort_cyc>0 asserts cancel (or rst)
    // during that cycle; glitch_cyc>0 pulses a stray start while busy.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int abort_cyc, input logic abort_rst,
                          input int glitch_cyc);
        logic [31:0] eq, er;
        logic edz;
        int lat = 0;
        logic busy_ok = 1'b1;
        logic done = 1'b0;
        logic aborted = 1'b0;
        model(a, b, s, eq, er, edz);
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            start_i = 1'b0; cancel_i = 1'b0; rst = 1'b0;
            signed_i = 1'($urandom); dividend_i = $urandom; divisor_i = $urandom;
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                done = 1'b1; aborted = 1'b1;
            end else if (ready_o) begin
                lat = c; done = 1'b1;
            end else if (!busy_o) begin
                busy_ok = 1'b0;
            end
            if (!done && c == glitch_cyc) start_i = 1'b1;
            if (!done && c == abort_cyc) begin
                if (abort_rst) rst = 1'b1;
                else cancel_i = 1'b1;
            end
        end
        if (aborted) begin
            chk({tag, "_abort_ready"}, 32'(ready_o), 32'd0);
            chk({tag, "_abort_busy"}, 32'(busy_o), 32'd0);
            chk({tag, "_abort_busy_before"}, 32'(busy_ok), 32'd1);
            if (abort_rst) begin
                prev_q = 32'd0; prev_r = 32'd0;
                chk({tag, "_rst_dz"}, 32'(div_zero_o), 32'd0);
            end
            chk({tag, "_abort_q"}, quotient_o, prev_q);
            chk({tag, "_abort_r"}, remainder_o, prev_r);
            lat = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (ready_o) lat++;
            end
            chk({tag, "_no_stale_ready"}, 32'(lat), 32'd0);
        end else begin
            chk({tag, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd2 : 32'd33);
            chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
            chk({tag, "_busy_at_ready"}, 32'(busy_o), 32'd1);
            chk({tag, "_q"}, quotient_o, eq);
            chk({tag, "_r"}, remainder_o, er);
            chk({tag, "_dz"}, 32'(div_zero_o), 32'(edz));
            prev_q = eq; prev_r = er;
            @(negedge clk);
            chk({tag, "_ready_pulse"}, 32'(ready_o), 32'd0);
            chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
            chk({tag, "_q_hold"}, quotient_o, eq);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic rs;
        rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; cancel_i = 1'b1;
        dividend_i = 32'd5; divisor_i = 32'd1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_dz", 32'(div_zero_o), 32'd0);
        chk("rst_q", quotient_o, 32'd0);
        chk("rst_r", remainder_o, 32'd0);
        rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk);

        run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0, 0);
        chk("divu_100_7_q_const", prev_q, 32'd14);
        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, 0);
        chk("div_m7_2_q_const", quotient_o, 32'hFFFF_FFFD);
        chk("div_m7_2_r_const", remainder_o, 32'hFFFF_FFFF);
        run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0, 0);
        chk("div_7_m2_r_const", remainder_o, 32'h0000_0001);
        run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 0);
        chk("div_ovf_q_const", quotient_o, 32'h8000_0000);
        run_op("divu_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0);
        chk("divu_ovf_r_const", remainder_o, 32'h8000_0000);
        run_op("div_by_zero", 32'd123, 32'd0, 1'b1, 0, 1'b0, 0);
        run_op("divu_9_3", 32'd9, 32'd3, 1'b0, 0, 1'b0, 0);
        chk("divu_9_3_q_const", quotient_o, 32'd3);
        run_op("cancel", 32'd1000, 32'd3, 1'b0, 10, 1'b0, 0);
        run_op("divu_50_5", 32'd50, 32'd5, 1'b0, 0, 1'b0, 0);
        chk("divu_50_5_q_const", quotient_o, 32'd10);
        run_op("midrst", 32'd77777, 32'd13, 1'b0, 20, 1'b1, 0);
        run_op("glitch", 32'hFFFF_FF00, 32'd9, 1'b1, 0, 1'b0, 5);
        run_op("cancel_divz", 32'd4, 32'd0, 1'b0, 1, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom);
            run_op("rand", ra, rb, rs, 0, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
